comparator_result_debouncer: RTL and testbench

- Sits directly downstream of the 8-bit comparator and consumes its three one-hot result flags, qualified by a sample strobe.
- Filters glitches by requiring a new result to persist for a set number of valid samples before committing it.
- Outputs the committed relation, a one-cycle change pulse, a saturating transition counter, and a sticky flag for malformed (non-one-hot) inputs.

---
 rtl/comparator_result_debouncer_if.sv | 39 +++
 rtl/comparator_result_debouncer.sv | 116 +++++++++++
 tb/tb_comparator_result_debouncer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/comparator_result_debouncer_if.sv
// Bundles the comparator flags, sample strobe, clear and debounced results into one port.
// master drives the comparator side; slave is the debouncer.
interface comparator_result_debouncer_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 Sample_Valid_In;
    logic                 A_Less_Than_B_In;
    logic                 A_Equal_To_B_In;
    logic                 A_Greater_Than_B_In;
    logic                 Clear_In;
    logic [1:0]           State_Out;
    logic                 Change_Pulse_Out;
    logic [CNT_WIDTH-1:0] Transition_Count_Out;
    logic                 Invalid_Flag_Out;

    modport master (
        output Sample_Valid_In,
        output A_Less_Than_B_In,
        output A_Equal_To_B_In,
        output A_Greater_Than_B_In,
        output Clear_In,
        input  State_Out,
        input  Change_Pulse_Out,
        input  Transition_Count_Out,
        input  Invalid_Flag_Out
    );

    modport slave (
        input  Sample_Valid_In,
        input  A_Less_Than_B_In,
        input  A_Equal_To_B_In,
        input  A_Greater_Than_B_In,
        input  Clear_In,
        output State_Out,
        output Change_Pulse_Out,
        output Transition_Count_Out,
        output Invalid_Flag_Out
    );
endinterface

// File: rtl/comparator_result_debouncer.sv
// Debounces one-hot comparator flags: a new relation must persist for PERSIST_COUNT valid
// samples before it is committed; also counts transitions and flags malformed samples.
module comparator_result_debouncer #(
    parameter int unsigned PERSIST_COUNT = 4,
    parameter int unsigned CNT_WIDTH     = 8
) (
    input logic                         Clock_In,
    input logic                         Reset_N_In,
    comparator_result_debouncer_if.slave bus
);
    typedef enum logic [1:0] {
        StUnknown = 2'b00,
        StLess    = 2'b01,
        StEqual   = 2'b10,
        StGreater = 2'b11
    } state_e;

    localparam int unsigned PersW = (PERSIST_COUNT > 1) ? $clog2(PERSIST_COUNT) : 1;
    localparam logic [PersW:0] PersTarget = (PersW + 1)'(PERSIST_COUNT);

    state_e               state_q, state_d;
    state_e               cand_q, cand_d;
    logic [PersW-1:0]     pers_q, pers_d;
    logic                 pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 inv_q, inv_d;

    state_e               code;
    logic                 well_formed;
    logic                 commit;
    logic [PersW:0]       pers_inc;

    // X/Z or multi-hot flags fall through to the default and count as malformed.
    always_comb begin
        code        = StUnknown;
        well_formed = 1'b0;
        case ({bus.A_Less_Than_B_In, bus.A_Equal_To_B_In, bus.A_Greater_Than_B_In})
            3'b100:  begin code = StLess;    well_formed = 1'b1; end
            3'b010:  begin code = StEqual;   well_formed = 1'b1; end
            3'b001:  begin code = StGreater; well_formed = 1'b1; end
            default: begin code = StUnknown; well_formed = 1'b0; end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        pers_d   = pers_q;
        pulse_d  = 1'b0;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        commit   = 1'b0;
        pers_inc = {1'b0, pers_q} + 1'b1;

        if (bus.Sample_Valid_In) begin
            if (!well_formed) begin
                inv_d  = 1'b1;
                pers_d = '0;
            end else if (code == state_q) begin
                pers_d = '0;
                cand_d = code;
            end else if (code == cand_q) begin
                if (pers_inc == PersTarget) begin
                    commit = 1'b1;
                end else begin
                    pers_d = pers_inc[PersW-1:0];
                end
            end else begin
                cand_d = code;
                if (PERSIST_COUNT == 1) begin
                    commit = 1'b1;
                end else begin
                    pers_d = PersW'(1);
                end
            end

            if (commit) begin
                state_d = code;
                pulse_d = 1'b1;
                pers_d  = '0;
                // Leaving UNKNOWN is the first lock, not a transition.
                if (state_q != StUnknown && cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        if (bus.Clear_In) begin
            cnt_d = '0;
            inv_d = 1'b0;
        end
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= StUnknown;
            cand_q  <= StUnknown;
            pers_q  <= '0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            pers_q  <= pers_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    assign bus.State_Out            = state_q;
    assign bus.Change_Pulse_Out     = pulse_q;
    assign bus.Transition_Count_Out = cnt_q;
    assign bus.Invalid_Flag_Out     = inv_q;
endmodule

// File: tb/tb_comparator_result_debouncer.sv
// Directed bench: drivers push hand-computed expected outputs into per-DUT queues,
// monitors pop and compare after every clock edge.
module tb_comparator_result_debouncer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    comparator_result_debouncer_if #(.CNT_WIDTH(8)) bus_a ();
    comparator_result_debouncer_if #(.CNT_WIDTH(2)) bus_b ();

    comparator_result_debouncer #(.PERSIST_COUNT(4), .CNT_WIDTH(8)) dut_a (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus_a.slave)
    );

    comparator_result_debouncer #(.PERSIST_COUNT(1), .CNT_WIDTH(2)) dut_b (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus_b.slave)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    // Expected word layout: {state[1:0], pulse, count[7:0], invalid}
    function automatic logic [11:0] act_a();
        return {bus_a.State_Out, bus_a.Change_Pulse_Out, bus_a.Transition_Count_Out,
                bus_a.Invalid_Flag_Out};
    endfunction

    function automatic logic [11:0] act_b();
        return {bus_b.State_Out, bus_b.Change_Pulse_Out, 6'b0, bus_b.Transition_Count_Out,
                bus_b.Invalid_Flag_Out};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got state=%b pulse=%b cnt=%0d inv=%b, want state=%b pulse=%b cnt=%0d inv=%b",
                     name, act[11:10], act[9], act[8:1], act[0],
                     exp[11:10], exp[9], exp[8:1], exp[0]);
        end else begin
            passed++;
        end
    endtask

    task automatic va(input bit v, input logic [2:0] leg, input bit clr,
                      input logic [1:0] s, input bit p, input int n, input bit i);
        @(negedge clk);
        bus_a.Sample_Valid_In     = v;
        bus_a.A_Less_Than_B_In    = leg[2];
        bus_a.A_Equal_To_B_In     = leg[1];
        bus_a.A_Greater_Than_B_In = leg[0];
        bus_a.Clear_In            = clr;
        qa.push_back({s, p, 8'(n), i});
    endtask

    task automatic vb(input bit v, input logic [2:0] leg, input bit clr,
                      input logic [1:0] s, input bit p, input int n, input bit i);
        @(negedge clk);
        bus_b.Sample_Valid_In     = v;
        bus_b.A_Less_Than_B_In    = leg[2];
        bus_b.A_Equal_To_B_In     = leg[1];
        bus_b.A_Greater_Than_B_In = leg[0];
        bus_b.Clear_In            = clr;
        qb.push_back({s, p, 8'(n), i});
    endtask

    task automatic idle_all();
        @(negedge clk);
        bus_a.Sample_Valid_In = 1'b0;
        bus_a.Clear_In        = 1'b0;
        bus_b.Sample_Valid_In = 1'b0;
        bus_b.Clear_In        = 1'b0;
        @(posedge clk);
        #2;
    endtask

    int unsigned idx_a = 0;
    int unsigned idx_b = 0;

    always begin
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            check($sformatf("dutA_vec%0d", idx_a), act_a(), qa.pop_front());
            idx_a++;
        end
        if (qb.size() > 0) begin
            check($sformatf("dutB_vec%0d", idx_b), act_b(), qb.pop_front());
            idx_b++;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, want completion",
                 total);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.Sample_Valid_In = 0; bus_a.Clear_In = 0;
        bus_a.A_Less_Than_B_In = 0; bus_a.A_Equal_To_B_In = 0; bus_a.A_Greater_Than_B_In = 0;
        bus_b.Sample_Valid_In = 0; bus_b.Clear_In = 0;
        bus_b.A_Less_Than_B_In = 0; bus_b.A_Equal_To_B_In = 0; bus_b.A_Greater_Than_B_In = 0;
        rst_n = 1'b0;
        #1;
        check("reset_a", act_a(), 12'h000);
        check("reset_b", act_b(), 12'h000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // UNKNOWN -> LESS after 4 samples, first commit not counted
        va(1, 3'b100, 0, 2'b00, 0, 0, 0);
        va(1, 3'b100, 0, 2'b00, 0, 0, 0);
        va(1, 3'b100, 0, 2'b00, 0, 0, 0);
        va(1, 3'b100, 0, 2'b01, 1, 0, 0);
        // 3 G, one L resets progress, then 4 G commit
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b100, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b01, 0, 0, 0);
        va(1, 3'b001, 0, 2'b11, 1, 1, 0);
        // EQUAL with 2-cycle gaps between samples
        for (int k = 0; k < 3; k++) begin
            va(1, 3'b010, 0, 2'b11, 0, 1, 0);
            va(0, 3'b000, 0, 2'b11, 0, 1, 0);
            va(0, 3'b000, 0, 2'b11, 0, 1, 0);
        end
        va(1, 3'b010, 0, 2'b10, 1, 2, 0);
        // back to LESS
        va(1, 3'b100, 0, 2'b10, 0, 2, 0);
        va(1, 3'b100, 0, 2'b10, 0, 2, 0);
        va(1, 3'b100, 0, 2'b10, 0, 2, 0);
        va(1, 3'b100, 0, 2'b01, 1, 3, 0);
        // 2 E, malformed L+G, then 3 E hold, 4th E commits
        va(1, 3'b010, 0, 2'b01, 0, 3, 0);
        va(1, 3'b010, 0, 2'b01, 0, 3, 0);
        va(1, 3'b101, 0, 2'b01, 0, 3, 1);
        va(1, 3'b010, 0, 2'b01, 0, 3, 1);
        va(1, 3'b010, 0, 2'b01, 0, 3, 1);
        va(1, 3'b010, 0, 2'b01, 0, 3, 1);
        va(1, 3'b010, 0, 2'b10, 1, 4, 1);
        va(0, 3'b000, 0, 2'b10, 0, 4, 1);
        va(0, 3'b000, 1, 2'b10, 0, 0, 0);
        // clear beats a coincident invalid-set; 000 is malformed
        va(1, 3'b000, 1, 2'b10, 0, 0, 0);
        va(1, 3'b000, 0, 2'b10, 0, 0, 1);
        // LESS, then 3 E in flight, then async reset
        va(1, 3'b100, 0, 2'b10, 0, 0, 1);
        va(1, 3'b100, 0, 2'b10, 0, 0, 1);
        va(1, 3'b100, 0, 2'b10, 0, 0, 1);
        va(1, 3'b100, 0, 2'b01, 1, 1, 1);
        va(1, 3'b010, 0, 2'b01, 0, 1, 1);
        va(1, 3'b010, 0, 2'b01, 0, 1, 1);
        va(1, 3'b010, 0, 2'b01, 0, 1, 1);
        idle_all();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("async_reset_a", act_a(), 12'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        va(1, 3'b010, 0, 2'b00, 0, 0, 0);
        va(1, 3'b010, 0, 2'b00, 0, 0, 0);
        va(1, 3'b010, 0, 2'b00, 0, 0, 0);
        va(1, 3'b010, 0, 2'b10, 1, 0, 0);
        idle_all();

        // PERSIST_COUNT=1, CNT_WIDTH=2: immediate commits, count saturates at 3
        vb(1, 3'b100, 0, 2'b01, 1, 0, 0);
        vb(1, 3'b001, 0, 2'b11, 1, 1, 0);
        vb(1, 3'b100, 0, 2'b01, 1, 2, 0);
        vb(1, 3'b001, 0, 2'b11, 1, 3, 0);
        vb(1, 3'b100, 0, 2'b01, 1, 3, 0);
        vb(1, 3'b001, 0, 2'b11, 1, 3, 0);
        vb(1, 3'b100, 1, 2'b01, 1, 0, 0);
        vb(1, 3'b100, 0, 2'b01, 0, 0, 0);
        vb(1, 3'b011, 0, 2'b01, 0, 0, 1);
        idle_all();

        if (qa.size() != 0 || qb.size() != 0) begin
            total++;
            $display("FAIL queue_drain: got %0d/%0d pending, want 0/0", qa.size(), qb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
